// File: rtl/btn_event_pkg.sv
// Shared types and defaults for the button event generator.
// Build option: BTN_EVENT_GEN_REPEAT_EN enables auto-repeat.
package btn_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } btn_state_e;

  localparam int LONG_CYC_DEF   = 50000000;
  localparam int REPEAT_CYC_DEF = 10000000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Level history and edge indications for the button input.
// History resets high so a held button never looks like a fresh press.
module btn_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic din_q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_q <= 1'b1;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;

endmodule

// File: rtl/btn_event_gen.sv
// Button press/release/long/repeat event strobes, all registered.
// Build option: BTN_EVENT_GEN_REPEAT_EN enables auto-repeat.
module btn_event_gen
  import btn_event_pkg::*;
#(
  parameter int LONG_CYC   = LONG_CYC_DEF,
  parameter int REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int CW = $clog2(max2(LONG_CYC, REPEAT_CYC)) + 1;
  localparam logic [CW-1:0] LONG_M1 = CW'(LONG_CYC - 1);

  btn_state_e    state;
  logic [CW-1:0] cnt;
  logic          din_q;
  logic          rise;
  logic          fall;

  btn_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .din_q (din_q),
    .rise  (rise),
    .fall  (fall)
  );

`ifdef BTN_EVENT_GEN_REPEAT_EN
  localparam logic [CW-1:0] REP_M1 = CW'(REPEAT_CYC - 1);
  logic rpt_q;
  assign repeat_pulse = rpt_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      held          <= 1'b0;
`ifdef BTN_EVENT_GEN_REPEAT_EN
      rpt_q         <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
`ifdef BTN_EVENT_GEN_REPEAT_EN
      rpt_q         <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (rise) begin
            press_pulse <= 1'b1;
            held        <= 1'b1;
            cnt         <= '0;
            state       <= PRESSED;
          end
        end
        PRESSED: begin
          // release wins over a long press landing on the same edge
          if (fall) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            cnt           <= '0;
            state         <= IDLE;
          end else if (cnt == LONG_M1) begin
            long_pulse <= 1'b1;
            cnt        <= '0;
            state      <= LONG;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG: begin
          if (fall) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            cnt           <= '0;
            state         <= IDLE;
`ifdef BTN_EVENT_GEN_REPEAT_EN
          end else if (cnt == REP_M1) begin
            rpt_q <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        default: begin
          held  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  logic unused_din_q;
  assign unused_din_q = din_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen, LONG_CYC=8, REPEAT_CYC=4.
// Repeat expectations follow BTN_EVENT_GEN_REPEAT_EN.
module tb_btn_event_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din = 1'b0;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  btn_event_gen #(
    .LONG_CYC   (8),
    .REPEAT_CYC (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .din           (din),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         p;
    logic [4:0] v;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

`ifdef BTN_EVENT_GEN_REPEAT_EN
  localparam int RP1 = 22;
  localparam int RP2 = 26;
`else
  localparam int RP1 = -1;
  localparam int RP2 = -1;
`endif

  // order: held, press, release, long, repeat
  initial begin
    forever begin
      logic [4:0] got;
      exp_t e;
      @(posedge clk);
      #1;
      got = {held, press_pulse, release_pulse, long_pulse, repeat_pulse};
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (got !== e.v) begin
          n_bad++;
          $display("FAIL %s p=%0d got=%b want=%b (held,prs,rel,lng,rpt)",
                   e.tag, e.p, got, e.v);
        end
      end else if (got[3:0] != 4'b0) begin
        n_bad++;
        $display("FAIL unexpected_pulse got=%b want=%b", got, 5'b0);
      end
    end
  end

  function automatic logic in_rng(input int p, input int a, input int b);
    return (p >= a) && (p <= b);
  endfunction

  task automatic scn(
    input string tag,
    input int hA, input int hB, input int h2A, input int h2B,
    input int rA, input int rB,
    input int pr1, input int pr2, input int rl1, input int rl2,
    input int lg, input int rp1, input int rp2,
    input int hd1A, input int hd1B, input int hd2A, input int hd2B
  );
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    din   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e.tag = {tag, "_rst"};
      e.p   = -2 + i;
      e.v   = 5'b0;
      q.push_back(e);
      @(negedge clk);
    end
    for (int p = 0; p < 36; p++) begin
      reset = !(p >= rA && p < rB);
      din   = in_rng(p, hA, hB) || in_rng(p, h2A, h2B);
      e.tag = tag;
      e.p   = p;
      e.v[4] = (p >= hd1A && p < hd1B) || (p >= hd2A && p < hd2B);
      e.v[3] = (p == pr1) || (p == pr2);
      e.v[2] = (p == rl1) || (p == rl2);
      e.v[1] = (p == lg);
      e.v[0] = (p == rp1) || (p == rp2);
      q.push_back(e);
      @(negedge clk);
    end
  endtask

  initial begin
    scn("short", 10, 13, 1, 0, -1, -1,
        10, -1, 14, -1, -1, -1, -1, 10, 14, 0, 0);
    scn("long_rpt", 10, 29, 1, 0, -1, -1,
        10, -1, 30, -1, 18, RP1, RP2, 10, 30, 0, 0);
    scn("edge_long", 10, 17, 1, 0, -1, -1,
        10, -1, 18, -1, -1, -1, -1, 10, 18, 0, 0);
    scn("one_cyc", 10, 10, 1, 0, -1, -1,
        10, -1, 11, -1, -1, -1, -1, 10, 11, 0, 0);
    scn("mid_rst", 10, 24, 28, 31, 15, 20,
        10, 28, -1, 32, -1, -1, -1, 10, 15, 28, 32);
    begin
      int k;
      k = 0;
      while (q.size() > 0 && k < 10) begin
        @(posedge clk);
        k++;
      end
      #2;
      if (q.size() > 0) begin
        n_bad++;
        $display("FAIL drain left=%0d want=0", q.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
